// File: rtl/bist_pattern_ctrl.sv
// bist_pattern_ctrl: built-in self-test sequencer for a small combinational target.
// It steps an exhaustive ascending pattern sequence onto the target and folds each
// response into a MISR. It then compares the final signature with a golden value
// and holds the pass/fail result until the next run, abort or reset.
module bist_pattern_ctrl #(
    parameter int                 PAT_W  = 2,
    parameter int                 RESP_W = 1,
    parameter int                 SIG_W  = 8,
    parameter logic [SIG_W-1:0]   POLY   = SIG_W'(8'h1D)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic [RESP_W-1:0] pattout,
    output logic [PAT_W-1:0]  pattin,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature
);

    // One extra counter bit lets the last pattern be recognised by the carry-out,
    // so the wrap from the top pattern back to 0 is never confused with pattern 0.
    localparam int CNT_W = PAT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               pass_q, pass_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [SIG_W-1:0]   misr_next;

    // MISR step and pattern-counter increment, used only while applying patterns.
    always_comb begin
        misr_next = (sig_q << 1) ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(pattout);
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    // Next-state logic: sequencing, signature compaction and the final compare.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_APPLY;
                    cnt_d   = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    sig_d = misr_next;
                    cnt_d = cnt_inc;
                    // Carry into the extra bit marks the edge absorbing the last pattern;
                    // the low bits driving pattin have wrapped to 0 on this same edge.
                    if (cnt_inc[PAT_W]) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    pass_d  = (sig_q == golden_sig);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end else if (start) begin
                    // Each run re-seeds the MISR so results are independent.
                    state_d = S_APPLY;
                    cnt_d   = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                sig_d   = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset that overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs come straight from registers or from the registered state.
    always_comb begin
        pattin    = cnt_q[PAT_W-1:0];
        busy      = (state_q == S_APPLY) || (state_q == S_CHECK);
        done      = (state_q == S_DONE);
        pass      = pass_q;
        signature = sig_q;
    end

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Testbench for bist_pattern_ctrl: table-driven runs, randomized truth tables
// against a reference model, and hand-written abort/reset/restart sequences.
module tb_bist_pattern_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] golden_sig;
    logic [0:0] pattout;
    logic [1:0] pattin;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;

    // Target selection: 0 = greater-than gate, 1 = stuck-at-0, 2 = stuck-at-1, 3 = truth table
    logic [1:0] mode;
    logic [3:0] tt;

    int tests_run = 0;
    int tests_failed = 0;

    bist_pattern_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .golden_sig (golden_sig),
        .pattout    (pattout),
        .pattin     (pattin),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational target model driven by the DUT's pattern bus.
    always_comb begin
        case (mode)
            2'd0:    pattout = pattin[1] & ~pattin[0];
            2'd1:    pattout = 1'b0;
            2'd2:    pattout = 1'b1;
            default: pattout = tt[pattin];
        endcase
    end

    // Target response for pattern p, from the target's definition.
    function automatic logic resp_of(input logic [1:0] m, input logic [3:0] t, input int p);
        logic [1:0] pv;
        pv = p[1:0];
        case (m)
            2'd0:    return pv[1] & ~pv[0];
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return t[pv];
        endcase
    endfunction

    // Reference signature: fold all four responses with plain arithmetic mod 256.
    function automatic logic [7:0] model_sig(input logic [1:0] m, input logic [3:0] t);
        int s;
        s = 0;
        for (int p = 0; p < 4; p++) begin
            s = ((s * 2) % 256) ^ ((s >= 128) ? 32'h1D : 0) ^ int'(resp_of(m, t, p));
        end
        return s[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge and wait for done; check latency and result.
    task automatic run_and_check(input string name, input logic [7:0] exp_sig, input logic exp_pass);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'd5);
        check({name, "_sig"}, 32'(signature), 32'(exp_sig));
        check({name, "_pass"}, 32'(pass), 32'(exp_pass));
        check({name, "_busy_in_done"}, 32'(busy), 32'd0);
        $display("[TB] %s: sig=%02h pass=%0d latency=%0d", name, signature, pass, n);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] tt;
        logic [7:0] golden;
        logic [7:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] steps [4];
        logic [7:0] ref_sig;

        vecs[0] = '{2'd0, 4'h0, 8'h02, 8'h02, 1'b1};
        vecs[1] = '{2'd0, 4'h0, 8'h03, 8'h02, 1'b0};
        vecs[2] = '{2'd1, 4'h0, 8'h02, 8'h00, 1'b0};
        vecs[3] = '{2'd1, 4'h0, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{2'd2, 4'h0, 8'h02, 8'h0F, 1'b0};
        vecs[5] = '{2'd2, 4'h0, 8'h0F, 8'h0F, 1'b1};
        vecs[6] = '{2'd3, 4'h1, 8'h08, 8'h08, 1'b1};
        vecs[7] = '{2'd3, 4'hA, 8'h05, 8'h05, 1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; golden_sig = 8'h00;
        mode = 2'd0; tt = 4'h0;
        tick();
        tick();
        check("reset_pattin", 32'(pattin), 32'd0);
        check("reset_sig", 32'(signature), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven runs
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            tt = vecs[i].tt;
            golden_sig = vecs[i].golden;
            run_and_check($sformatf("vec%0d", i), vecs[i].exp_sig, vecs[i].exp_pass);
        end

        // Cycle-by-cycle trace of a greater-than run
        mode = 2'd0; golden_sig = 8'h02;
        steps[0] = 8'h00; steps[1] = 8'h00; steps[2] = 8'h01; steps[3] = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("trace_e0_pattin", 32'(pattin), 32'd0);
        check("trace_e0_sig", 32'(signature), 32'd0);
        check("trace_e0_done", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("trace_e%0d_sig", k + 1), 32'(signature), 32'(steps[k]));
            check($sformatf("trace_e%0d_pattin", k + 1), 32'(pattin), 32'((k + 1) % 4));
            check($sformatf("trace_e%0d_busy", k + 1), 32'(busy), 32'd1);
            check($sformatf("trace_e%0d_done", k + 1), 32'(done), 32'd0);
            $display("[TB] trace edge %0d: pattin=%0d sig=%02h", k + 1, pattin, signature);
        end
        tick();
        check("trace_e5_done", 32'(done), 32'd1);
        check("trace_e5_pass", 32'(pass), 32'd1);
        check("trace_e5_busy", 32'(busy), 32'd0);

        // Reset while in DONE with pass=1; start in the same cycle is ignored
        rst_n = 1'b0; start = 1'b1;
        tick();
        check("rst_done_sig", 32'(signature), 32'd0);
        check("rst_done_done", 32'(done), 32'd0);
        check("rst_done_pass", 32'(pass), 32'd0);
        check("rst_done_busy", 32'(busy), 32'd0);
        check("rst_done_pattin", 32'(pattin), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("rst_start_ignored_busy", 32'(busy), 32'd0);
        $display("[TB] reset in DONE: busy=%0d done=%0d pass=%0d", busy, done, pass);

        // Abort during the second APPLY cycle, then a clean rerun
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_sig", 32'(signature), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pattin", 32'(pattin), 32'd0);
        tick();
        check("abort_stays_idle", 32'(busy), 32'd0);
        $display("[TB] abort in APPLY: busy=%0d sig=%02h", busy, signature);
        run_and_check("rerun_after_abort", 8'h02, 1'b1);

        // Abort in DONE clears the held result
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_state_done", 32'(done), 32'd0);
        check("abort_done_state_pass", 32'(pass), 32'd0);

        // Abort overrides start in IDLE
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_over_start", 32'(busy), 32'd0);

        // Start held high through DONE restarts immediately with a fresh signature
        mode = 2'd2; golden_sig = 8'h0F;
        run_and_check("pre_restart", 8'h0F, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_pass", 32'(pass), 32'd0);
        check("restart_sig", 32'(signature), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        check("restart_result_sig", 32'(signature), 32'h0F);
        check("restart_result_done", 32'(done), 32'd1);

        // Randomized truth tables against the reference model
        for (int r = 0; r < 30; r++) begin
            mode = 2'd3;
            tt = 4'($urandom);
            ref_sig = model_sig(mode, tt);
            golden_sig = ($urandom_range(0, 1) == 1) ? ref_sig : 8'($urandom);
            run_and_check($sformatf("rand%0d_tt%0h", r, tt), ref_sig, golden_sig == ref_sig);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
